// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle execute controller for a simple RV core.
// Sequences fetch, decode, memory access and writeback with a response watchdog.
module exec_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        dmem_req_valid,
  output logic        dmem_req_wen,
  input  logic        dmem_req_ready,
  input  logic        dmem_resp_valid,
  input  logic        dmem_resp_err,
  output logic [31:0] inst_q,
  output logic        inst_valid,
  input  logic        dec_wen,
  input  logic        dec_mem_valid,
  input  logic        dec_mem_wen,
  input  logic        dec_is_ecall,
  input  logic        dec_is_ebreak,
  input  logic        dec_illegal,
  output logic        rf_we,
  output logic        pc_we,
  output logic        halt,
  output logic        trap,
  output logic [2:0]  trap_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [3:0] {
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT,
    TRAP
  } state_t;

  typedef struct packed {
    logic wen;
    logic mem;
    logic mwen;
  } flags_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [2:0] C_ILL   = 3'd0;
  localparam logic [2:0] C_ECALL = 3'd1;
  localparam logic [2:0] C_IERR  = 3'd2;
  localparam logic [2:0] C_DERR  = 3'd3;
  localparam logic [2:0] C_TMO   = 3'd4;

  state_t      state_q, state_d;
  flags_t      flags_q, flags_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [2:0]  cause_q, cause_d;
  logic [31:0] inst_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ret_q, ret_d;
  logic        run_q;

  // run_q holds off the first request until one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_REQ;
      flags_q <= '0;
      wcnt_q  <= '0;
      cause_q <= '0;
      inst_q  <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      wcnt_q  <= wcnt_d;
      cause_q <= cause_d;
      inst_q  <= inst_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    flags_d        = flags_q;
    wcnt_d         = wcnt_q;
    cause_d        = cause_q;
    inst_d         = inst_q;
    ret_d          = ret_q;
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_req_wen   = 1'b0;
    inst_valid     = 1'b0;
    rf_we          = 1'b0;
    pc_we          = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        if (run_q) begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            state_d = FETCH_WAIT;
            wcnt_d  = '0;
          end
        end
      end
      FETCH_WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = TRAP;
            cause_d = C_IERR;
          end else begin
            inst_d  = imem_resp_data;
            state_d = DECODE;
          end
        end else if (wcnt_q == TO_LAST) begin
          state_d = TRAP;
          cause_d = C_TMO;
        end
      end
      DECODE: begin
        inst_valid   = 1'b1;
        flags_d.wen  = dec_wen;
        flags_d.mem  = dec_mem_valid;
        flags_d.mwen = dec_mem_wen;
        if (dec_illegal) begin
          state_d = TRAP;
          cause_d = C_ILL;
        end else if (dec_is_ecall) begin
          state_d = TRAP;
          cause_d = C_ECALL;
        end else if (dec_is_ebreak) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = flags_q.mem ? MEM_REQ : WB;
      end
      MEM_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_req_wen   = flags_q.mwen;
        if (dmem_req_ready) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        wcnt_d = wcnt_q + 8'd1;
        if (dmem_resp_valid) begin
          if (dmem_resp_err) begin
            state_d = TRAP;
            cause_d = C_DERR;
          end else begin
            state_d = WB;
          end
        end else if (wcnt_q == TO_LAST) begin
          state_d = TRAP;
          cause_d = C_TMO;
        end
      end
      WB: begin
        pc_we   = 1'b1;
        rf_we   = flags_q.wen;
        ret_d   = ret_q + 32'd1;
        state_d = FETCH_REQ;
      end
      HALT: state_d = HALT;
      TRAP: state_d = TRAP;
      default: state_d = FETCH_REQ;
    endcase
  end

  assign halt = (state_q == HALT);
  assign trap = (state_q == TRAP);
  assign trap_cause = trap ? cause_q : 3'd0;

  always_comb begin
    cyc_d = cyc_q;
    if (run_q && !halt && !trap) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl: directed instruction sequences.
// Expected WB/HALT/TRAP events are queued; a negedge monitor pops and compares.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        dmem_req_valid;
  logic        dmem_req_wen;
  logic        dmem_req_ready = 1'b0;
  logic        dmem_resp_valid = 1'b0;
  logic        dmem_resp_err = 1'b0;
  logic [31:0] inst_q;
  logic        inst_valid;
  logic        dec_wen = 1'b0;
  logic        dec_mem_valid = 1'b0;
  logic        dec_mem_wen = 1'b0;
  logic        dec_is_ecall = 1'b0;
  logic        dec_is_ebreak = 1'b0;
  logic        dec_illegal = 1'b0;
  logic        rf_we;
  logic        pc_we;
  logic        halt;
  logic        trap;
  logic [2:0]  trap_cause;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] SW    = 32'h0020a023;
  localparam logic [31:0] LW    = 32'h0000a103;
  localparam logic [31:0] EBRK  = 32'h00100073;
  localparam logic [31:0] ECALL = 32'h00000073;

  exec_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_wen(dmem_req_wen),
    .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_err(dmem_resp_err),
    .inst_q(inst_q),
    .inst_valid(inst_valid),
    .dec_wen(dec_wen),
    .dec_mem_valid(dec_mem_valid),
    .dec_mem_wen(dec_mem_wen),
    .dec_is_ecall(dec_is_ecall),
    .dec_is_ebreak(dec_is_ebreak),
    .dec_illegal(dec_illegal),
    .rf_we(rf_we),
    .pc_we(pc_we),
    .halt(halt),
    .trap(trap),
    .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // kind: 0 = writeback (a=rf_we, b=inst), 1 = halt, 2 = trap (a=cause); b=instret
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sbq[$];
  int   ncmp = 0;
  int   nerr = 0;
  logic halt_p = 1'b0;
  logic trap_p = 1'b0;
  int   drun = 0;
  int   dlast = 0;
  int   rf_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a,
                      input logic [31:0] b);
    exp_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t        e;
    logic        got;
    int          k;
    logic [31:0] a;
    logic [31:0] b;
    got = 1'b0;
    k = 0;
    a = '0;
    b = '0;
    if (pc_we) begin
      got = 1'b1; k = 0; a = {31'b0, rf_we}; b = inst_q;
    end else if (halt && !halt_p) begin
      got = 1'b1; k = 1; a = '0; b = instret_cnt;
    end else if (trap && !trap_p) begin
      got = 1'b1; k = 2; a = {29'b0, trap_cause}; b = instret_cnt;
    end
    halt_p = halt;
    trap_p = trap;
    if (got) begin
      if (sbq.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL sb_unexpected: got event kind %0d a=%h b=%h want none",
                 k, a, b);
      end else begin
        e = sbq.pop_front();
        chk("sb_kind", k, e.kind);
        chk("sb_a", a, e.a);
        chk("sb_b", b, e.b);
      end
    end
    if (dmem_req_valid) drun++;
    else if (drun != 0) begin
      dlast = drun;
      drun = 0;
    end
    if (rf_we) rf_cnt++;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic w, input logic m, input logic mw,
                         input logic ec, input logic eb, input logic il);
    dec_wen = w;
    dec_mem_valid = m;
    dec_mem_wen = mw;
    dec_is_ecall = ec;
    dec_is_ebreak = eb;
    dec_illegal = il;
  endtask

  // rsp < 0 withholds the response
  task automatic do_fetch(input logic [31:0] w, input int rdy, input int rsp,
                          input logic err, output logic [31:0] c0);
    int n;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("imem_req_seen", {31'b0, imem_req_valid}, 32'd1);
    c0 = cycle_cnt;
    repeat (rdy) step();
    chk("imem_valid_held", {31'b0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    if (rsp >= 0) begin
      repeat (rsp) step();
      imem_resp_valid = 1'b1;
      imem_resp_data = w;
      imem_resp_err = err;
      step();
      imem_resp_valid = 1'b0;
      imem_resp_err = 1'b0;
      imem_resp_data = '0;
    end
  endtask

  task automatic do_mem(input int rdy, input int rsp, input logic err,
                        input logic wen);
    int n;
    n = 0;
    while (dmem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("dmem_req_seen", {31'b0, dmem_req_valid}, 32'd1);
    repeat (rdy) step();
    chk("dmem_wen", {31'b0, dmem_req_wen}, {31'b0, wen});
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    if (rsp >= 0) begin
      repeat (rsp) step();
      dmem_resp_valid = 1'b1;
      dmem_resp_err = err;
      step();
      dmem_resp_valid = 1'b0;
      dmem_resp_err = 1'b0;
    end
  endtask

  // leading step lets the monitor see any terminal state first
  task automatic do_reset();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {21'b0, imem_req_valid, dmem_req_valid, dmem_req_wen,
                    inst_valid, rf_we, pc_we, halt, trap, trap_cause}, 32'd0);
    chk("rst_inst", inst_q, 32'd0);
    chk("rst_cyc", cycle_cnt, 32'd0);
    chk("rst_ret", instret_cnt, 32'd0);
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_err = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [31:0] c0;
    logic [31:0] cc;
    int          rf0;
    #1;
    chk("por_ctl", {23'b0, imem_req_valid, dmem_req_valid, inst_valid,
                    rf_we, pc_we, halt, trap, trap_cause[1:0]}, 32'd0);
    repeat (2) step();
    chk("rst_low_req", {31'b0, imem_req_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_no_edge_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    chk("first_req", {31'b0, imem_req_valid}, 32'd1);
    chk("first_cyc", cycle_cnt, 32'd0);

    // addi: register write, no memory, five cycles per instruction
    set_dec(1, 0, 0, 0, 0, 0);
    push(0, 32'd1, ADDI);
    do_fetch(ADDI, 0, 0, 1'b0, c0);
    chk("dec_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("dec_inst_q", inst_q, ADDI);
    step();
    chk("exec_inst_valid", {31'b0, inst_valid}, 32'd0);
    repeat (2) step();
    chk("addi_ret", instret_cnt, 32'd1);
    chk("addi_cycles", cycle_cnt - c0, 32'd5);

    // sw with slow dmem ready
    set_dec(0, 1, 1, 0, 0, 0);
    push(0, 32'd0, SW);
    do_fetch(SW, 1, 1, 1'b0, c0);
    do_mem(3, 1, 1'b0, 1'b1);
    step();
    chk("sw_valid_run", dlast, 32'd4);
    chk("sw_ret", instret_cnt, 32'd2);

    // lw: read with writeback
    set_dec(1, 1, 0, 0, 0, 0);
    push(0, 32'd1, LW);
    do_fetch(LW, 0, 2, 1'b0, c0);
    do_mem(0, 2, 1'b0, 1'b0);
    step();
    chk("lw_ret", instret_cnt, 32'd3);

    // ebreak halts, not retired
    set_dec(0, 0, 0, 0, 1, 0);
    push(1, 32'd0, 32'd3);
    do_fetch(EBRK, 0, 0, 1'b0, c0);
    step();
    cc = cycle_cnt;
    repeat (8) step();
    chk("halt_held", {31'b0, halt}, 32'd1);
    chk("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
    chk("halt_cyc_frozen", cycle_cnt, cc);
    chk("halt_ret", instret_cnt, 32'd3);

    // fetch timeout after four wait cycles
    do_reset();
    push(2, 32'd4, 32'd0);
    do_fetch(ADDI, 0, -1, 1'b0, c0);
    repeat (3) step();
    chk("tmo_not_yet", {31'b0, trap}, 32'd0);
    step();
    chk("tmo_trap", {31'b0, trap}, 32'd1);
    chk("tmo_cause", {29'b0, trap_cause}, 32'd4);

    // response on the last wait cycle wins
    do_reset();
    set_dec(1, 0, 0, 0, 0, 0);
    push(0, 32'd1, ADDI);
    do_fetch(ADDI, 0, 3, 1'b0, c0);
    chk("late_resp_decode", {31'b0, inst_valid}, 32'd1);
    repeat (3) step();
    chk("late_resp_ret", instret_cnt, 32'd1);

    // illegal outranks ecall
    set_dec(1, 0, 0, 1, 0, 1);
    push(2, 32'd0, 32'd1);
    do_fetch(32'hffffffff, 0, 0, 1'b0, c0);
    step();
    chk("ill_trap", {31'b0, trap}, 32'd1);

    // ecall outranks ebreak
    do_reset();
    set_dec(0, 0, 0, 1, 1, 0);
    push(2, 32'd1, 32'd0);
    do_fetch(ECALL, 0, 0, 1'b0, c0);
    step();
    chk("ecall_halt", {31'b0, halt}, 32'd0);

    // instruction fetch error
    do_reset();
    push(2, 32'd2, 32'd0);
    do_fetch(ADDI, 0, 1, 1'b1, c0);
    chk("ierr_cause", {29'b0, trap_cause}, 32'd2);

    // load data error: no register write
    do_reset();
    set_dec(1, 1, 0, 0, 0, 0);
    push(2, 32'd3, 32'd0);
    rf0 = rf_cnt;
    do_fetch(LW, 0, 0, 1'b0, c0);
    do_mem(0, 1, 1'b1, 1'b0);
    chk("derr_cause", {29'b0, trap_cause}, 32'd3);
    step();
    chk("derr_no_rf_we", rf_cnt, rf0);

    // data response timeout
    do_reset();
    set_dec(1, 1, 0, 0, 0, 0);
    push(2, 32'd4, 32'd0);
    do_fetch(LW, 0, 0, 1'b0, c0);
    do_mem(0, -1, 1'b0, 1'b0);
    repeat (4) step();
    chk("dtmo_trap", {31'b0, trap}, 32'd1);

    // reset in MEM_WAIT, stale response ignored, restart at fetch
    do_reset();
    set_dec(1, 1, 0, 0, 0, 0);
    do_fetch(LW, 0, 0, 1'b0, c0);
    do_mem(0, -1, 1'b0, 1'b0);
    do_reset();
    dmem_resp_valid = 1'b1;
    step();
    step();
    dmem_resp_valid = 1'b0;
    chk("restart_req", {31'b0, imem_req_valid}, 32'd1);
    set_dec(1, 0, 0, 0, 0, 0);
    push(0, 32'd1, ADDI);
    do_fetch(ADDI, 0, 0, 1'b0, c0);
    repeat (3) step();
    chk("restart_ret", instret_cnt, 32'd1);

    repeat (3) step();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Params: TIMEOUT, 255, max wait cycles for a memory response (8-bit counter range, 1..255).
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 imem_req_valid out 1, imem_req_ready in 1: fetch request handshake.
REQ-005 imem_resp_valid in 1, imem_resp_data in 32, imem_resp_err in 1: fetch response.
REQ-006 dmem_req_valid out 1, dmem_req_wen out 1, dmem_req_ready in 1: data access request handshake.
REQ-007 dmem_resp_valid in 1, dmem_resp_err in 1: data access response.
REQ-008 inst_q out 32: latched instruction word, drives decoder inst; inst_valid out 1: decoder enable.
REQ-009 dec_wen, dec_mem_valid, dec_mem_wen, dec_is_ecall, dec_is_ebreak, dec_illegal in 1 each: decoder results.
REQ-010 rf_we out 1: register-file write strobe; pc_we out 1: PC update strobe.
REQ-011 halt out 1, trap out 1, trap_cause out 3: terminal status.
REQ-012 cycle_cnt out 32, instret_cnt out 32: performance counters.

Function
REQ-013 States: FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, TRAP; exactly one active.
REQ-014 FETCH_REQ: imem_req_valid=1; on imem_req_ready=1 -> FETCH_WAIT; valid never withdrawn before ready.
REQ-015 FETCH_WAIT: on imem_resp_valid & !err -> latch inst_q<=imem_resp_data, -> DECODE; on resp_valid & err -> TRAP, cause=2.
REQ-016 DECODE: inst_valid=1 this cycle only; register dec_wen, dec_mem_valid, dec_mem_wen into internal flags.
REQ-017 DECODE priority: dec_illegal -> TRAP cause=0; else dec_is_ecall -> TRAP cause=1; else dec_is_ebreak -> HALT; else -> EXEC.
REQ-018 EXEC: single cycle; mem flag=1 -> MEM_REQ, else -> WB.
REQ-019 MEM_REQ: dmem_req_valid=1, dmem_req_wen=registered mem_wen flag; on dmem_req_ready -> MEM_WAIT.
REQ-020 MEM_WAIT: dmem_resp_valid & !err -> WB; dmem_resp_valid & err -> TRAP cause=3.
REQ-021 WB: pc_we=1, rf_we=registered wen flag, both for exactly one cycle; instret_cnt+=1; -> FETCH_REQ.
REQ-022 Watchdog: 8-bit wait counter cleared on entry to FETCH_WAIT/MEM_WAIT, +1 per cycle waiting; reaching TIMEOUT without response -> TRAP cause=4.
REQ-023 Response and timeout in same cycle: response wins.
REQ-024 HALT and TRAP terminal until reset; halt=1 resp. trap=1; no requests, strobes or counter updates.
REQ-025 trap_cause registered on TRAP entry, held; 0 when trap=0.
REQ-026 cycle_cnt +1 every cycle outside HALT/TRAP; both counters 32-bit, wrap 0xFFFFFFFF->0.
REQ-027 rf_we, pc_we, inst_valid, imem_req_valid, dmem_req_valid all 0 in every state not listed for them.
REQ-028 ebreak not counted in instret_cnt; no PC update on HALT/TRAP.

Reset
REQ-029 rst_n=0 immediately (no clock edge): state=FETCH_REQ-pending-release, all outputs 0, inst_q=0, counters 0, flags 0, trap_cause=0.
REQ-030 While rst_n=0, imem_req_valid=0; first request asserted on first clk edge after rst_n rises.
REQ-031 Reset mid-transaction (any WAIT state) abandons it; late responses after reset ignored until FETCH_WAIT re-entered.

Verification
REQ-032 Fetch addi (0x00100093), ready/resp 1 cycle later, no mem -> inst_valid 1 cycle, WB rf_we=1 pc_we=1, instret_cnt=1, 5 cycles total.
REQ-033 Fetch sw, dmem_req_ready delayed 3 cycles -> dmem_req_valid=1 held 4 cycles, dmem_req_wen=1, WB rf_we=0 pc_we=1.
REQ-034 Fetch 0x00100073 (ebreak) -> halt=1 after DECODE, instret_cnt unchanged, no further imem_req_valid.
REQ-035 imem_resp_valid withheld with TIMEOUT=4 -> trap=1, trap_cause=4 after 4 wait cycles; resp on 4th cycle instead -> DECODE.
REQ-036 dmem_resp_err=1 on load -> trap_cause=3, rf_we never asserted; rst_n pulse in MEM_WAIT -> all outputs 0 asynchronously, restart at fetch.
